// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the CPU
// instruction-fetch port and its load/store port. Data accesses win over
// fetches, accesses are never preempted, and stalls hold the requester
// until its one-cycle valid pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; grant data request first, else fetch
// ACC_D | data access on the memory bus, counter runs MEM_LAT-1 .. 0
// ACC_I | fetch access on the memory bus, counter runs MEM_LAT-1 .. 0
// DONE  | one-cycle valid pulse for the finished access; no grant here
module unified_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    input  logic              d_req_i,
    input  logic              d_wr_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic              d_stall_o,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_D = 2'd1,
        ACC_I = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_data_q, sel_data_d;   // finished access was a data access
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    // State, latency counter, latched request and read-data registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            sel_data_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            sel_data_q <= sel_data_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Grant, access sequencing and read-data capture on the last access cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        sel_data_d = sel_data_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (d_req_i) begin
                    state_d    = ACC_D;
                    addr_d     = d_addr_i;
                    wr_d       = d_wr_i;
                    wdata_d    = d_wdata_i;
                    sel_data_d = 1'b1;
                    cnt_d      = CNT_LOAD;
                end else if (if_req_i) begin
                    state_d    = ACC_I;
                    addr_d     = if_addr_i;
                    wr_d       = 1'b0;
                    sel_data_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                end
            end
            ACC_D, ACC_I: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (state_q == ACC_I) begin
                        if_rdata_d = mem_rdata_i;
                    end else if (!wr_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en_o    = (state_q == ACC_D) || (state_q == ACC_I);
    assign mem_wr_o    = (state_q == ACC_D) && wr_q;
    assign mem_addr_o  = {addr_q[ADDR_W-1:1], 1'b0};
    assign mem_wdata_o = wdata_q;

    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_valid_o  = (state_q == DONE) && !sel_data_q;
    assign d_valid_o   = (state_q == DONE) && sel_data_q;

    // Stalls are forced low while reset is held so the CPU is not frozen by it.
    assign if_stall_o  = rst_n_i && if_req_i && !if_valid_o;
    assign d_stall_o   = rst_n_i && d_req_i && !d_valid_o;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: two random requesters, a
// fixed-latency memory that only presents real data in the last access
// cycle, random resets, and a transaction-level timeline model.
module tb_unified_mem_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int LAT  = 4;
    localparam int NCYC = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, d_req, d_wr;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_valid, if_stall, d_valid, d_stall, mem_en, mem_wr;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_valid_o(if_valid), .if_stall_o(if_stall),
        .d_req_i(d_req), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata), .d_valid_o(d_valid), .d_stall_o(d_stall),
        .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Physical memory (written by the DUT) and the model's view of it.
    logic [DW-1:0] tbmem [32];
    logic [DW-1:0] shadow[32];

    // Requester state.
    bit            if_on, d_on, dwr_v;
    logic [AW-1:0] if_a, d_a;
    logic [DW-1:0] d_wd;

    // Model: one active transaction placed on a timeline.
    bit            act, kd, gw;
    int            g, free_at;
    logic [AW-1:0] ga;
    logic [DW-1:0] gwd;
    logic [DW-1:0] exp_if_rd, exp_d_rd;
    bit            en_e, vi_e, vd_e, vi_prev, vd_prev, rst_v, prev_rst;

    // Memory-side latency tracking.
    int            run;
    bit            prev_en;

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbmem[i]  = 16'($urandom);
            shadow[i] = tbmem[i];
        end
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        if_on = 0; d_on = 0; dwr_v = 0; if_a = '0; d_a = '0; d_wd = '0;
        act = 0; kd = 0; gw = 0; g = -100; free_at = 0; ga = '0; gwd = '0;
        exp_if_rd = '0; exp_d_rd = '0;
        vi_prev = 0; vd_prev = 0; prev_rst = 0; run = 0; prev_en = 0;

        for (int c = 0; c < NCYC; c++) begin
            cyc = c;

            // Memory: real data only in the LAT-th consecutive enabled cycle.
            if (mem_en === 1'b1) run = prev_en ? run + 1 : 0;
            else                 run = 0;
            prev_en   = (mem_en === 1'b1);
            mem_rdata = (prev_en && run == LAT - 1) ? tbmem[mem_addr[5:1]] : 16'($urandom);

            // Reset: two cycles at start with both requests high, then rare random pulses.
            rst_v = (c < 2) ? 1'b0 : ((c >= 20 && $urandom_range(0, 79) == 0) ? 1'b0 : 1'b1);

            if (c < 2) begin
                if_on = 1; if_a = 16'h0010;
                d_on  = 1; d_a  = 16'h0020; dwr_v = 0; d_wd = '0;
            end else begin
                if (!prev_rst || vi_prev) if_on = 0;
                else if (!if_on && $urandom_range(0, 2) == 0) begin
                    if_on = 1; if_a = 16'($urandom_range(0, 63));
                end
                if (!prev_rst || vd_prev) d_on = 0;
                else if (!d_on && $urandom_range(0, 2) == 0) begin
                    d_on = 1; d_a = 16'($urandom_range(0, 63));
                    dwr_v = ($urandom_range(0, 1) == 1); d_wd = 16'($urandom);
                end
            end
            rst_n = rst_v; if_req = if_on; if_addr = if_a;
            d_req = d_on; d_wr = dwr_v; d_addr = d_a; d_wdata = d_wd;

            // Grant when free: data first, then fetch.
            if (rst_v && c >= free_at && (d_on || if_on)) begin
                act = 1; g = c; free_at = c + LAT + 2;
                kd  = d_on;
                ga  = d_on ? d_a : if_a;
                gw  = d_on && dwr_v;
                gwd = d_wd;
            end

            en_e = act && c > g && c <= g + LAT;
            vi_e = act && !kd && c == g + LAT + 1;
            vd_e = act &&  kd && c == g + LAT + 1;
            if (vi_e) exp_if_rd = shadow[ga[5:1]];
            if (vd_e) begin
                if (gw) shadow[ga[5:1]] = gwd;
                else    exp_d_rd = shadow[ga[5:1]];
            end

            @(negedge clk);
            if (mem_en === 1'b1 && mem_wr === 1'b1) tbmem[mem_addr[5:1]] = mem_wdata;
            if (c >= 1) begin
                chk("mem_en",   32'(mem_en),   32'(en_e));
                chk("if_valid", 32'(if_valid), 32'(vi_e));
                chk("d_valid",  32'(d_valid),  32'(vd_e));
                chk("if_stall", 32'(if_stall), 32'(rst_v && if_on && !vi_e));
                chk("d_stall",  32'(d_stall),  32'(rst_v && d_on && !vd_e));
                chk("if_rdata", 32'(if_rdata), 32'(exp_if_rd));
                chk("d_rdata",  32'(d_rdata),  32'(exp_d_rd));
                if (en_e) begin
                    chk("mem_addr", 32'(mem_addr), 32'({ga[AW-1:1], 1'b0}));
                    chk("mem_wr",   32'(mem_wr),   32'(kd && gw));
                    if (kd && gw) chk("mem_wdata", 32'(mem_wdata), 32'(gwd));
                end else begin
                    chk("mem_wr_idle", 32'(mem_wr), 32'(0));
                end
            end

            @(posedge clk);
            #1;
            if (!rst_v) begin
                if (act && c < g + LAT + 1) begin
                    act = 0;
                    // Abandoned store leaves the word undefined: follow the memory.
                    if (kd && gw) shadow[ga[5:1]] = tbmem[ga[5:1]];
                end
                free_at = c + 1; exp_if_rd = '0; exp_d_rd = '0;
            end
            vi_prev = vi_e; vd_prev = vd_e; prev_rst = rst_v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the CPU's instruction-fetch port and its data (LW/SW) port.
- Replaces the separate instruction and data memory instances in the CPU top level.
- Sequences each access with an FSM and latency counter, returns read data with a one-cycle valid pulse, and drives stall signals so the CPU can freeze the PC and pipeline until its access completes.

Parameters:
- ADDR_W, 16, address width (byte addresses; word-aligned accesses).
- DATA_W, 16, data/word width.
- MEM_LAT, 4, memory access cycles per request; minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held high until if_valid is seen.
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_valid  out  1  one-cycle pulse: if_rdata valid, fetch done.
- if_stall  out  1  fetch pending and not yet done.
- d_req  in  1  data request; held high until d_valid is seen.
- d_wr  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; registered.
- d_valid  out  1  one-cycle pulse: data access done (load or store).
- d_stall  out  1  data access pending and not yet done.
- mem_en  out  1  memory enable; high for the whole access.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address, bit 0 forced to 0.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle.

Behaviour:
- FSM states: IDLE, ACC_D, ACC_I, DONE.
- IDLE:
  - d_req=1 → latch d_addr/d_wr/d_wdata, go to ACC_D.
  - Else if_req=1 → latch if_addr, go to ACC_I.
  - Else stay in IDLE.
  - Data has fixed priority over fetch when both requests are high.
- ACC_*:
  - mem_en=1; mem_addr = {latched addr[ADDR_W-1:1], 0}.
  - mem_wr = latched d_wr in ACC_D, 0 in ACC_I; mem_wdata = latched d_wdata.
  - All memory outputs held stable for exactly MEM_LAT cycles; down-counter loads MEM_LAT-1 on entry.
  - On the edge ending the cycle where the counter is 0: capture mem_rdata into d_rdata (ACC_D load) or if_rdata (ACC_I); go to DONE.
  - Stores do not change d_rdata.
- DONE:
  - Exactly one cycle; asserts d_valid or if_valid according to the finished access.
  - No grant is made in DONE; next state is IDLE.
  - Requester deasserts req in the cycle after valid.
- Latency: req high in IDLE cycle N → mem_en cycles N+1..N+MEM_LAT → valid in cycle N+MEM_LAT+1.
- Requests are never preempted. A request arriving mid-access waits; it is granted in the IDLE cycle after DONE.
- Stalls (combinational): if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid. Both forced to 0 while rst_n=0.
- Outside ACC_*: mem_en=0 and mem_wr=0. mem_addr/mem_wdata are don't-care there but are driven from the latched registers (no X).
- Reset (rst_n=0 at a rising edge, in any state):
  - State → IDLE; counter, latched registers, if_rdata, d_rdata → 0.
  - valids = 0, mem_en = 0, mem_wr = 0.
  - An in-flight access is abandoned with no valid; memory contents for an abandoned store are undefined.
- No combinational path from mem_rdata to any output.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with if_req=d_req=1 → mem_en, mem_wr, if_valid, d_valid, if_stall, d_stall all 0; if_rdata=d_rdata=0x0000.
2. Single fetch (MEM_LAT=4): if_req=1, if_addr=0x0010 at cycle 0; model returns 0xA5A5 → mem_en=1 with mem_addr=0x0010 in cycles 1–4; if_valid=1 and if_rdata=0xA5A5 in cycle 5; if_stall=1 in cycles 0–4.
3. Simultaneous requests at cycle 0: d_req load at 0x0020 (mem=0x1111), if_req at 0x0002 (mem=0x2222) → d_valid cycle 5 with d_rdata=0x1111; fetch granted in IDLE cycle 6; mem_en cycles 7–10; if_valid cycle 11 with if_rdata=0x2222.
4. Store then load: d_wr=1, d_addr=0x0031, d_wdata=0x1234 → mem_addr=0x0030, mem_wr=1 in cycles 1–4, d_valid cycle 5, d_rdata unchanged. A following load of 0x0030 returns d_rdata=0x1234.
5. Late data request: fetch issued at cycle 0, d_req rises at cycle 2 → fetch runs uninterrupted, if_valid cycle 5; data access mem_en cycles 7–10; d_valid cycle 11.
6. Reset mid-access: fetch issued at cycle 0, rst_n=0 at cycle 2 → mem_en=0 from cycle 3, no if_valid. After release, a re-issued fetch completes with normal MEM_LAT+1 latency.
